// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SLICE_W = 2;

    // Result encoding, ordered as {e, g, l}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/slice_cmp2.sv
// Combinational unsigned compare of two 2-bit slices.
module slice_cmp2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first multi-cycle magnitude compare, two bits per clock, early exit
// on the first unequal slice.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;

    logic [SLICE_W-1:0] sl_a, sl_b;
    logic               sl_eq, sl_gt, sl_lt;
    logic               decided;

    assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

    slice_cmp2 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .eq (sl_eq),
        .gt (sl_gt),
        .lt (sl_lt)
    );

    // The scan ends on any unequal slice, or on an equal bottom slice
    assign decided = sl_gt | sl_lt | (sl_eq & (idx_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (decided) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        busy_d = busy_q;
        done_d = 1'b0;
        res_d  = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    idx_d  = CW'(NSLICE - 1);
                    res_d  = RES_NONE;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                if (decided) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    res_d  = sl_gt ? RES_GT : (sl_lt ? RES_LT : RES_EQ);
                end else begin
                    idx_d = idx_q - CW'(1);
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= RES_NONE;
        end else begin
            idx_q  <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            busy_q <= busy_d;
            done_q <= done_d;
            res_q  <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign e    = res_q[2];
    assign g    = res_q[1];
    assign l    = res_q[0];

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Sequential MSB-first magnitude comparator for WIDTH-bit unsigned operands. It walks the operands two bits per clock through a combinational 2-bit slice comparator and stops at the first unequal slice. It reports a one-hot equal/greater/less result with a done pulse. It sits directly downstream of the operand source and wraps the 2-bit slice compare stage, turning it into a multi-cycle wide-word compare.

## Interface
- WIDTH, 8: operand width in bits; must be even and ≥ 2. The number of slices is NSLICE = WIDTH/2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high. Clears all state immediately.
- start  input  1  request a compare. Accepted only when busy = 0.
- a  input  WIDTH  operand A. Sampled on the accepting edge.
- b  input  WIDTH  operand B. Sampled on the accepting edge.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse: the result is valid.
- e  output  1  A == B.
- g  output  1  A > B.
- l  output  1  A < B.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: scanning slices.
- Reset: state = IDLE. busy, done, e, g, l, slice index and operand registers are all 0.
- IDLE, start = 1 at the clock edge:
  - Latch a and b.
  - Set slice index = NSLICE-1 (the top slice is bits [WIDTH-1:WIDTH-2]).
  - Clear e, g and l.
  - Set busy = 1 and go to RUN.
- RUN, each cycle: compare slice {A[2i+1:2i], B[2i+1:2i]} using the slice comparator.
  - Slice greater: set g = 1, busy = 0, done = 1, go to IDLE.
  - Slice less: set l = 1, busy = 0, done = 1, go to IDLE.
  - Slice equal and i = 0: set e = 1, busy = 0, done = 1, go to IDLE.
  - Slice equal and i > 0: decrement i and stay in RUN.
- start while busy = 1 is ignored. Operands are not resampled and no error is flagged.
- e, g and l are mutually exclusive and hold their value after done until the next accepted start clears them.
- start may be asserted in the cycle done is high. busy is already 0 in that cycle, so the request is accepted; done is not extended.
- a and b may change freely while busy. Only the latched copies are used.
- Unsigned compare only. No X propagation from the unlatched inputs.

## Timing
- Let T0 be the accepting edge.
- Latency is k cycles, where k = NSLICE − (index of the first unequal slice). For all-equal operands, k = NSLICE.
- busy is high from after T0 until the edge T0+k. done and the result flags are registered at T0+k. done is high for exactly the cycle after T0+k.
- Best case: 1 cycle (MSB slice differs). Worst case: NSLICE cycles. For the WIDTH = 8 default the worst case is 4.
- Throughput: a new compare can be accepted at the edge immediately after the done cycle begins, i.e. one compare per k+1 edges at most, with no dead cycle beyond that.
- rst asserted mid-RUN: outputs drop to 0 immediately (asynchronously). There is no done pulse for the aborted compare. The first start after rst deasserts is accepted normally.

## Structure
- Shared package (cmp_pkg):
  - State enum {IDLE, RUN}.
  - Constant SLICE_W = 2.
  - One-hot result encoding constants for {e, g, l}.
- One sub-module, slice_cmp2: purely combinational 2-bit compare with outputs eq, gt, lt. It is instantiated once and fed by a slice multiplexer indexed by the slice counter.
- Slice counter width: $clog2(NSLICE), minimum 1 bit.
- Top level holds the FSM, operand registers, counter and registered outputs only.

## Test plan
- a=8'hA5, b=8'hA5, start pulse → busy for 4 cycles, then done with e=1, g=0, l=0. Flags hold until the next start.
- a=8'h80, b=8'h7F → done 1 cycle after acceptance with g=1. The early exit is checked: busy is high for exactly 1 cycle.
- a=8'h12, b=8'h13 → l=1 after 4 cycles (decided on the LSB slice).
- Accept a=8'h40, b=8'h00. Pulse start with a=8'h00, b=8'hFF while busy → ignored. The result is g=1 from the first operands and there is exactly one done pulse.
- Assert rst during the 2nd RUN cycle of an 8'h0F vs 8'h0E compare → busy, done and e/g/l are 0 immediately with no done. A subsequent compare of 8'h01 vs 8'h02 yields l=1 after 4 cycles.
- Back-to-back: assert start in the done cycle of compare 8'hC0 vs 8'h40 (result g) with new operands 8'h03 vs 8'h03 → the second compare is accepted. e, g and l clear at that edge, and e=1 follows after 4 cycles.
